// File: rtl/mul_mant_seq_pkg.sv
// Shared FPU definitions for the iterative mantissa multiplier.
//   - binary32 field widths, product width, exponent bias / max
//   - FSM state enum, operand-class enum
package mul_mant_seq_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int PROD_W   = 48;
  localparam int E_OUT_W  = 10;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } op_cls_e;

endpackage

// File: rtl/mul_mant_seq_if.sv
// Handshake + result bundle for mul_mant_seq.
//   master: drives start/a/b, observes busy/done and the result.
//   slave : the multiplier side.
interface mul_mant_seq_if;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        s_g;
  logic [47:0] m_out;
  logic [9:0]  e_out;
  logic        zero;
  logic        inf;
  logic        nan;
  logic        ovf;
  logic        unf;

  modport master (
    output start, a, b,
    input  busy, done, s_g, m_out, e_out, zero, inf, nan, ovf, unf
  );

  modport slave (
    input  start, a, b,
    output busy, done, s_g, m_out, e_out, zero, inf, nan, ovf, unf
  );

endinterface

// File: rtl/mul_mant_seq_fp_classify.sv
// fp_classify: combinational binary32 operand classifier.
//   op  : binary32 operand
//   cls : ZERO (exp=0, denormals flushed), INF, NAN, or NORM
module fp_classify
  import mul_mant_seq_pkg::*;
(
  input  logic [31:0] op,
  output op_cls_e     cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = op[30:23];
  assign frac_f = op[22:0];

  always_comb begin
    cls = CLS_NORM;
    if (exp_f == '0)
      cls = CLS_ZERO;
    else if (exp_f == EXP_W'(EXP_MAX))
      cls = (frac_f == '0) ? CLS_INF : CLS_NAN;
  end

endmodule

// File: rtl/mul_mant_seq.sv
// mul_mant_seq: iterative binary32 mantissa multiplier feeding the rounder.
//   clk, rst_n : clock, async active-low reset
//   s (slave)  : start/a/b in; busy, done pulse, sign, 48-bit normalised
//                product (hidden 1 at bit 47), signed 10-bit biased exponent,
//                zero/inf/nan/ovf/unf flags.
// Fixed latency: done rises 24/RADIX_BITS+1 cycles after the start edge.
module mul_mant_seq
  import mul_mant_seq_pkg::*;
#(
  parameter int RADIX_BITS = 1,
  parameter int EXP_BIAS   = mul_mant_seq_pkg::EXP_BIAS
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_mant_seq_if.slave  s
);

  localparam int ITERS = MANT_W / RADIX_BITS;
  localparam int CNT_W = 5;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [MANT_W-1:0]        mcand_q, mpl_q;
  logic [PROD_W-1:0]        acc_q;
  logic signed [E_OUT_W-1:0] exp_q;
  logic                     sign_q;
  op_cls_e                  cls_a_q, cls_b_q;

  logic                     busy_q, done_q, s_g_q;
  logic [PROD_W-1:0]        m_out_q;
  logic [E_OUT_W-1:0]       e_out_q;
  logic                     zero_q, inf_q, nan_q, ovf_q, unf_q;

  op_cls_e                  cls_a, cls_b;
  logic                     launch, last_iter;
  logic [PROD_W-1:0]        pp_sh;
  logic [E_OUT_W-1:0]       exp_sum;
  logic signed [E_OUT_W-1:0] exp_n;
  logic [PROD_W-1:0]        mant_n;
  logic                     f_nan, f_inf, f_zero, special;

  fp_classify u_cls_a (.op(s.a), .cls(cls_a));
  fp_classify u_cls_b (.op(s.b), .cls(cls_b));

  assign launch    = (state_q == ST_IDLE) && s.start;
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  // Ea + Eb - bias in 10-bit two's complement; wraps correctly for underflow.
  assign exp_sum = E_OUT_W'({2'b00, s.a[30:23]}) + E_OUT_W'({2'b00, s.b[30:23]})
                 - E_OUT_W'(EXP_BIAS);

  // Partial product for this digit, aligned to its weight.
  assign pp_sh = (PROD_W'(mcand_q) * PROD_W'(mpl_q[RADIX_BITS-1:0]))
                 << (cnt_q * RADIX_BITS);

  // Product of two [1,2) mantissas lies in [1,4): at most one left shift.
  assign exp_n  = acc_q[PROD_W-1] ? exp_q + 1'b1 : exp_q;
  assign mant_n = acc_q[PROD_W-1] ? acc_q : acc_q << 1;

  assign f_nan   = (cls_a_q == CLS_NAN) || (cls_b_q == CLS_NAN) ||
                   ((cls_a_q == CLS_INF) && (cls_b_q == CLS_ZERO)) ||
                   ((cls_a_q == CLS_ZERO) && (cls_b_q == CLS_INF));
  assign f_inf   = !f_nan && ((cls_a_q == CLS_INF) || (cls_b_q == CLS_INF));
  assign f_zero  = !f_nan && !f_inf &&
                   ((cls_a_q == CLS_ZERO) || (cls_b_q == CLS_ZERO));
  assign special = f_nan || f_inf || f_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (s.start)   state_d = ST_MUL;
      ST_MUL:  if (last_iter) state_d = ST_NORM;
      ST_NORM:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      mpl_q   <= '0;
      acc_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      cls_a_q <= CLS_ZERO;
      cls_b_q <= CLS_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_g_q   <= 1'b0;
      m_out_q <= '0;
      e_out_q <= '0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        mcand_q <= {1'b1, s.a[22:0]};
        mpl_q   <= {1'b1, s.b[22:0]};
        exp_q   <= $signed(exp_sum);
        sign_q  <= s.a[31] ^ s.b[31];
        cls_a_q <= cls_a;
        cls_b_q <= cls_b;
        acc_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
      if (state_q == ST_MUL) begin
        acc_q <= acc_q + pp_sh;
        mpl_q <= mpl_q >> RADIX_BITS;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_NORM) begin
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        s_g_q   <= sign_q;
        nan_q   <= f_nan;
        inf_q   <= f_inf;
        zero_q  <= f_zero;
        m_out_q <= special ? '0 : mant_n;
        e_out_q <= special ? '0 : exp_n;
        ovf_q   <= !special && (exp_n >= 10'sd255);
        unf_q   <= !special && (exp_n <= 10'sd0);
      end
    end
  end

  assign s.busy  = busy_q;
  assign s.done  = done_q;
  assign s.s_g   = s_g_q;
  assign s.m_out = m_out_q;
  assign s.e_out = e_out_q;
  assign s.zero  = zero_q;
  assign s.inf   = inf_q;
  assign s.nan   = nan_q;
  assign s.ovf   = ovf_q;
  assign s.unf   = unf_q;

endmodule

// File: doc/mul_mant_seq.md
Name: mul_mant_seq

Overview:
- Iterative single-precision mantissa multiplier. It sits directly upstream of the FPU multiplier rounding stage.
- It accepts two IEEE-754 binary32 operands on a START handshake and produces the sign and the 10-bit exponent.
- The 48-bit product is normalised so the hidden 1 sits at bit 47 and the fraction at bits 46:0, ready for rounding.
- Special-operand classification flags are produced alongside the product.

Parameters:
- RADIX_BITS, 1, multiplier bits retired per iteration. Legal values: 1, 2, 3, 4, 6, 8 (must divide 24).
- EXP_BIAS, 127, exponent bias subtracted from the exponent sum.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  launch request; sampled only in IDLE.
- A  in  32  operand A, binary32.
- B  in  32  operand B, binary32.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse; all result outputs are valid from this cycle on.
- S_G  out  1  result sign, A[31]^B[31].
- M_OUT  out  48  normalised product; bit 47 is the hidden 1.
- E_OUT  out  10  signed two's-complement biased result exponent.
- ZERO  out  1  result is zero.
- INF  out  1  result is infinity.
- NAN  out  1  result is NaN.
- OVF  out  1  E_OUT >= 255 on a finite nonzero result.
- UNF  out  1  E_OUT <= 0 on a finite nonzero result.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = IDLE, iteration counter = 0.
  - BUSY, DONE, S_G, ZERO, INF, NAN, OVF, UNF = 0; M_OUT = 0; E_OUT = 0.
- FSM states: IDLE, MUL, NORM.
- IDLE:
  - START=1 latches A and B.
  - Mantissas get the hidden 1 prepended (24 bits). Exponent sum Ea+Eb-EXP_BIAS is formed as 10-bit signed.
  - Accumulator cleared, counter cleared, BUSY=1, next state = MUL.
- MUL:
  - Each cycle adds (multiplicand × low RADIX_BITS bits of multiplier), shifted by counter×RADIX_BITS, into the 48-bit accumulator.
  - Multiplier shifts right by RADIX_BITS; counter increments.
  - After 24/RADIX_BITS iterations, next state = NORM.
- NORM (one cycle):
  - If accumulator[47]=1: M_OUT = accumulator, exponent +1.
  - Else: M_OUT = accumulator<<1, exponent unchanged.
  - Registers S_G, E_OUT and the flags; DONE=1 for this one cycle; BUSY=0; next state = IDLE.
- Latency is fixed regardless of operand class. DONE is asserted exactly 24/RADIX_BITS+1 cycles after the START sample edge (25 cycles for RADIX_BITS=1).
- Operand classification (denormals are flushed to zero):
  - Exp=0 → zero.
  - Exp=255 with fraction=0 → inf.
  - Exp=255 with fraction≠0 → NaN.
- Flag priority:
  - NAN if either operand is NaN, or inf×zero.
  - Else INF if either operand is inf.
  - Else ZERO if either operand is zero.
  - When any of these is set: M_OUT=0, E_OUT=0, OVF=UNF=0.
- OVF/UNF are evaluated on the post-normalisation exponent.
- Outputs hold their values until the next DONE. Results are not cleared on a new START.
- START while BUSY is ignored; no queuing.
- A and B are don't-care after the START cycle.
- Reset asserted mid-operation aborts immediately to the reset state; no DONE is produced.
- Accumulator width is 48 bits; no carry beyond bit 47 is possible (max 0xFFFFFF² < 2^48).

Decomposition:
- Shared FPU package holds:
  - binary32 field widths (EXP_W=8, FRAC_W=23, MANT_W=24, PROD_W=48);
  - EXP_BIAS, EXP_MAX=255;
  - the FSM state enum;
  - the operand-class typedef {ZERO, NORM, INF, NAN}.
- One sub-module is natural: fp_classify. It is a combinational per-operand classifier and is instantiated twice.

Test Plan:
- A=0x3F800000, B=0x3F800000, START 1 cycle → DONE at cycle 25; M_OUT=0x800000000000, E_OUT=127, S_G=0, all flags 0.
- A=0x3FC00000, B=0x3FC00000 → M_OUT=0x900000000000, E_OUT=128, S_G=0.
- A=0xC0000000, B=0x40400000 → S_G=1, M_OUT=0xC00000000000, E_OUT=129. Repeat with RADIX_BITS=4: DONE at cycle 7, identical results.
- A=0x00000000, B=0x40400000 → ZERO=1, M_OUT=0, E_OUT=0. A=0x7F800000, B=0x00000000 → NAN=1. A=0x7F800000, B=0x3F800000 → INF=1.
- A=0x7F000000, B=0x7F000000 → E_OUT=381, OVF=1. A=0x00800000, B=0x00800000 → E_OUT=-125 (0x383), UNF=1.
- START at cycle 5 during BUSY is ignored (DONE at cycle 25 only). RST_N low at cycle 10 → outputs zero asynchronously, no DONE. A new START after release completes normally.
